bias_sched: RTL

Controller that sequences the bias adder across output channels. It loads a per-channel bias table over a valid/ready port and then streams convolution results through the adder. It presents the correct channel's bias on every accepted beat and realigns valid/last with the adder's one-cycle registered output. It sits between the accumulator output stream and the bias adder, ahead of activation/pooling.

---
 rtl/bias_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bias_sched.sv
// rtl/bias_sched.sv - bias table loader and per-channel bias sequencer for the bias adder
// Loads a bias table, then presents table[channel] on each accepted beat and realigns valid/last.
module bias_sched #(
  parameter int NUM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_reuse,
  input  logic [ADDR_WIDTH:0]   cfg_chans,
  input  logic [CNT_WIDTH-1:0]  cfg_pixels,
  input  logic                  bias_valid,
  input  logic [NUM_WIDTH-1:0]  bias_data,
  output logic                  bias_ready,
  input  logic                  up_valid,
  output logic                  up_ready,
  output logic [NUM_WIDTH-1:0]  bias,
  output logic                  dn_valid,
  output logic                  dn_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH:0]    chans_q, chans_d;
  logic [CNT_WIDTH-1:0]   pixels_q, pixels_d;
  logic [ADDR_WIDTH-1:0]  load_idx_q, load_idx_d;
  logic [ADDR_WIDTH-1:0]  chan_idx_q, chan_idx_d;
  logic [CNT_WIDTH-1:0]   pix_cnt_q, pix_cnt_d;
  logic                   dn_valid_q, dn_valid_d;
  logic                   last_q, last_d;
  logic                   done_q, done_d;
  logic [NUM_WIDTH-1:0]   tbl_q [DEPTH];

  logic                   cfg_ok;
  logic                   load_hs;
  logic                   accept;
  logic                   tbl_we;
  logic [ADDR_WIDTH:0]    chans_m1;
  logic [CNT_WIDTH-1:0]   pixels_m1;

  assign chans_m1  = chans_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign pixels_m1 = pixels_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  assign cfg_ok    = (cfg_chans != '0) && (cfg_chans <= DEPTH_W) && (cfg_pixels != '0);
  assign load_hs   = (state_q == LOAD) && bias_valid;
  assign accept    = (state_q == RUN) && up_valid;
  assign tbl_we    = load_hs;

  always_comb begin
    state_d    = state_q;
    chans_d    = chans_q;
    pixels_d   = pixels_q;
    load_idx_d = load_idx_q;
    chan_idx_d = chan_idx_q;
    pix_cnt_d  = pix_cnt_q;
    dn_valid_d = accept;
    last_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start && cfg_ok) begin
          chans_d    = cfg_chans;
          pixels_d   = cfg_pixels;
          load_idx_d = '0;
          chan_idx_d = '0;
          pix_cnt_d  = '0;
          state_d    = cfg_reuse ? RUN : LOAD;
        end
      end
      LOAD: begin
        if (load_hs) begin
          if ({1'b0, load_idx_q} == chans_m1) begin
            load_idx_d = '0;
            state_d    = RUN;
          end else begin
            load_idx_d = load_idx_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (pix_cnt_q == pixels_m1) begin
            pix_cnt_d = '0;
            // Final beat of final channel closes the run in the same edge.
            if ({1'b0, chan_idx_q} == chans_m1) begin
              chan_idx_d = '0;
              state_d    = IDLE;
              last_d     = 1'b1;
              done_d     = 1'b1;
            end else begin
              chan_idx_d = chan_idx_q + 1'b1;
            end
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      chans_q    <= '0;
      pixels_q   <= '0;
      load_idx_q <= '0;
      chan_idx_q <= '0;
      pix_cnt_q  <= '0;
      dn_valid_q <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      chans_q    <= chans_d;
      pixels_q   <= pixels_d;
      load_idx_q <= load_idx_d;
      chan_idx_q <= chan_idx_d;
      pix_cnt_q  <= pix_cnt_d;
      dn_valid_q <= dn_valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  // Table is deliberately unreset so contents survive for reuse runs.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_q[load_idx_q] <= bias_data;
    end
  end

  assign bias_ready = (state_q == LOAD);
  assign up_ready   = (state_q == RUN);
  assign busy       = (state_q != IDLE);
  assign bias       = (state_q == RUN) ? tbl_q[chan_idx_q] : '0;
  assign dn_valid   = dn_valid_q;
  assign dn_last    = last_q;
  assign done       = done_q;

endmodule
